// File: rtl/decode_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage_pkg
//  Description : Shared constants, types and decode helpers for the
//                instruction decode stage (opcode values, instruction field
//                positions, architectural register count, operand-select
//                codes and the per-instruction decode record).
//  Revision    : 1.0  initial release
// ============================================================================
package decode_stage_pkg;

    localparam int C_XLEN      = 32;
    localparam int C_REG_IDX_W = 5;
    localparam int C_NUM_REGS  = 16;

    // Instruction field bit positions
    localparam int C_OPC_MSB   = 31;
    localparam int C_OPC_LSB   = 26;
    localparam int C_RS_MSB    = 25;
    localparam int C_RS_LSB    = 21;
    localparam int C_RT_MSB    = 20;
    localparam int C_RT_LSB    = 16;
    localparam int C_RD_MSB    = 15;
    localparam int C_RD_LSB    = 11;
    localparam int C_FUNCT_MSB = 5;
    localparam int C_FUNCT_LSB = 0;
    localparam int C_IMM_MSB   = 15;
    localparam int C_IMM_LSB   = 0;

    // Opcode values
    localparam logic [5:0] C_OPC_RTYPE = 6'h00;
    localparam logic [5:0] C_OPC_LW    = 6'h23;
    localparam logic [5:0] C_OPC_SW    = 6'h2B;

    // Operand source selected by the hazard unit
    typedef enum logic [1:0] {
        OPSEL_ZERO = 2'd0,
        OPSEL_EX   = 2'd1,
        OPSEL_WB   = 2'd2,
        OPSEL_BANK = 2'd3
    } opsel_t;

    typedef struct packed {
        logic [5:0]             opcode;
        logic [C_REG_IDX_W-1:0] rs;
        logic [C_REG_IDX_W-1:0] rt;
        logic [C_REG_IDX_W-1:0] dest;
        logic [5:0]             funct;
        logic [C_XLEN-1:0]      imm;
        logic                   use_rt;
        logic                   has_dest;
        logic                   mem_read;
        logic                   mem_write;
    } dec_t;

    // Splits an instruction into fields and classifies it by opcode.
    // Every class reads rs; only R-type and store also read rt.
    function automatic dec_t decode_instr(input logic [C_XLEN-1:0] instr);
        dec_t                   d;
        logic [C_REG_IDX_W-1:0] rd;
        d        = '0;
        rd       = instr[C_RD_MSB:C_RD_LSB];
        d.opcode = instr[C_OPC_MSB:C_OPC_LSB];
        d.rs     = instr[C_RS_MSB:C_RS_LSB];
        d.rt     = instr[C_RT_MSB:C_RT_LSB];
        d.funct  = instr[C_FUNCT_MSB:C_FUNCT_LSB];
        d.imm    = {{(C_XLEN-16){instr[C_IMM_MSB]}}, instr[C_IMM_MSB:C_IMM_LSB]};
        case (d.opcode)
            C_OPC_RTYPE: begin
                d.use_rt   = 1'b1;
                d.has_dest = 1'b1;
                d.dest     = rd;
            end
            C_OPC_LW: begin
                d.has_dest = 1'b1;
                d.dest     = d.rt;
                d.mem_read = 1'b1;
            end
            C_OPC_SW: begin
                d.use_rt    = 1'b1;
                d.mem_write = 1'b1;
            end
            default: begin
                d.has_dest = 1'b1;
                d.dest     = d.rt;
            end
        endcase
        return d;
    endfunction

    // The encoding has 5-bit fields but only 16 registers exist.
    function automatic logic reg_illegal(input logic [C_REG_IDX_W-1:0] idx);
        return (idx >= C_REG_IDX_W'(C_NUM_REGS));
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage_if
//  Description : Bundle of all decode-stage signals except clock and reset:
//                fetch handshake, register-bank read port, EX/WB bypass
//                buses, control inputs and the ID/EX pipeline register.
//                slave  : the decode stage itself
//                master : the surrounding pipeline / environment
//  Revision    : 1.0  initial release
// ============================================================================
interface decode_stage_if;
    import decode_stage_pkg::*;

    // Fetch side
    logic                   in_valid;
    logic                   in_ready;
    logic [C_XLEN-1:0]      instr;
    logic [C_XLEN-1:0]      pc;
    // Register bank
    logic [C_REG_IDX_W-1:0] rs;
    logic [C_REG_IDX_W-1:0] rt;
    logic [C_XLEN-1:0]      data_rs;
    logic [C_XLEN-1:0]      data_rt;
    // Bypass
    logic                   ex_fwd_en;
    logic [C_REG_IDX_W-1:0] ex_fwd_rd;
    logic [C_XLEN-1:0]      ex_fwd_data;
    logic                   wb_en;
    logic [C_REG_IDX_W-1:0] wb_rd;
    logic [C_XLEN-1:0]      wb_data;
    // Control
    logic                   flush;
    logic                   out_ready;
    logic                   ill_reg;
    // ID/EX register
    logic                   out_valid;
    logic [C_XLEN-1:0]      out_pc;
    logic [C_XLEN-1:0]      out_a;
    logic [C_XLEN-1:0]      out_b;
    logic [C_XLEN-1:0]      out_imm;
    logic [C_REG_IDX_W-1:0] out_rd;
    logic [5:0]             out_opcode;
    logic [5:0]             out_funct;
    logic                   out_mem_read;
    logic                   out_mem_write;
    logic                   out_reg_write;

    modport slave (
        input  in_valid, instr, pc, data_rs, data_rt,
               ex_fwd_en, ex_fwd_rd, ex_fwd_data, wb_en, wb_rd, wb_data,
               flush, out_ready,
        output in_ready, rs, rt, ill_reg,
               out_valid, out_pc, out_a, out_b, out_imm, out_rd,
               out_opcode, out_funct, out_mem_read, out_mem_write, out_reg_write
    );

    modport master (
        output in_valid, instr, pc, data_rs, data_rt,
               ex_fwd_en, ex_fwd_rd, ex_fwd_data, wb_en, wb_rd, wb_data,
               flush, out_ready,
        input  in_ready, rs, rt, ill_reg,
               out_valid, out_pc, out_a, out_b, out_imm, out_rd,
               out_opcode, out_funct, out_mem_read, out_mem_write, out_reg_write
    );

endinterface
`default_nettype wire

// File: rtl/decode_stage_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_unit
//  Description : Load-use hazard detection and per-operand bypass selection
//                for the decode stage.
//  Ports       : i_rs/i_rt/i_use_rt    source fields of the instruction in ID
//                i_id_valid/i_id_mem_read/i_id_rd  instruction held in ID/EX
//                i_ex_fwd_en/i_ex_fwd_rd  EX result bypass
//                i_wb_en/i_wb_rd          write-back bypass
//                o_hazard                 load-use stall request
//                o_sel_a/o_sel_b          operand source for rs / rt
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_unit
    import decode_stage_pkg::*;
(
    input  wire logic [C_REG_IDX_W-1:0] i_rs,
    input  wire logic [C_REG_IDX_W-1:0] i_rt,
    input  wire logic                   i_use_rt,
    input  wire logic                   i_id_valid,
    input  wire logic                   i_id_mem_read,
    input  wire logic [C_REG_IDX_W-1:0] i_id_rd,
    input  wire logic                   i_ex_fwd_en,
    input  wire logic [C_REG_IDX_W-1:0] i_ex_fwd_rd,
    input  wire logic                   i_wb_en,
    input  wire logic [C_REG_IDX_W-1:0] i_wb_rd,
    output logic                        o_hazard,
    output opsel_t                      o_sel_a,
    output opsel_t                      o_sel_b
);

    // Register 0 is hard-wired, so it never forwards; the younger EX result
    // wins over the older write-back value.
    function automatic opsel_t pick(input logic [C_REG_IDX_W-1:0] idx,
                                    input logic ex_en, input logic [C_REG_IDX_W-1:0] ex_rd,
                                    input logic wb_en, input logic [C_REG_IDX_W-1:0] wb_rd);
        if (idx == '0)
            return OPSEL_ZERO;
        else if (ex_en && (ex_rd == idx))
            return OPSEL_EX;
        else if (wb_en && (wb_rd == idx))
            return OPSEL_WB;
        else
            return OPSEL_BANK;
    endfunction

    logic w_load_in_idex;
    logic w_rs_match;
    logic w_rt_match;

    // A load's data is not available to bypass until a cycle after it
    // leaves ID/EX, so any consumer directly behind it must wait.
    assign w_load_in_idex = i_id_valid && i_id_mem_read && (i_id_rd != '0);
    assign w_rs_match     = (i_id_rd == i_rs);
    assign w_rt_match     = i_use_rt && (i_id_rd == i_rt);
    assign o_hazard       = w_load_in_idex && (w_rs_match || w_rt_match);

    assign o_sel_a = pick(i_rs, i_ex_fwd_en, i_ex_fwd_rd, i_wb_en, i_wb_rd);
    assign o_sel_b = pick(i_rt, i_ex_fwd_en, i_ex_fwd_rd, i_wb_en, i_wb_rd);

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : Instruction decode stage with operand bypassing, load-use
//                stall, illegal-register squash and the ID/EX register.
//  Ports       : clk  rising-edge clock
//                rst  asynchronous active-high reset
//                bus  decode_stage_if.slave - fetch handshake (in_valid,
//                     in_ready, instr, pc), bank read (rs, rt, data_rs,
//                     data_rt), bypass (ex_fwd_*, wb_*), control (flush,
//                     out_ready, ill_reg) and registered ID/EX outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module decode_stage
    import decode_stage_pkg::*;
(
    input  wire logic      clk,
    input  wire logic      rst,
    decode_stage_if.slave  bus
);

    dec_t                   w_dec;
    logic                   w_hazard;
    opsel_t                 w_sel_a;
    opsel_t                 w_sel_b;
    logic [C_XLEN-1:0]      w_opnd_a;
    logic [C_XLEN-1:0]      w_opnd_b;
    logic                   w_illegal;
    logic                   w_advance;
    logic                   w_in_ready;
    logic                   w_accept;

    logic                   r_out_valid;
    logic [C_XLEN-1:0]      r_out_pc;
    logic [C_XLEN-1:0]      r_out_a;
    logic [C_XLEN-1:0]      r_out_b;
    logic [C_XLEN-1:0]      r_out_imm;
    logic [C_REG_IDX_W-1:0] r_out_rd;
    logic [5:0]             r_out_opcode;
    logic [5:0]             r_out_funct;
    logic                   r_out_mem_read;
    logic                   r_out_mem_write;
    logic                   r_out_reg_write;
    logic                   r_ill_reg;

    assign w_dec = decode_instr(bus.instr);

    assign bus.rs = w_dec.rs;
    assign bus.rt = w_dec.rt;

    hazard_unit u_hazard (
        .i_rs          (w_dec.rs),
        .i_rt          (w_dec.rt),
        .i_use_rt      (w_dec.use_rt),
        .i_id_valid    (r_out_valid),
        .i_id_mem_read (r_out_mem_read),
        .i_id_rd       (r_out_rd),
        .i_ex_fwd_en   (bus.ex_fwd_en),
        .i_ex_fwd_rd   (bus.ex_fwd_rd),
        .i_wb_en       (bus.wb_en),
        .i_wb_rd       (bus.wb_rd),
        .o_hazard      (w_hazard),
        .o_sel_a       (w_sel_a),
        .o_sel_b       (w_sel_b)
    );

    always_comb begin
        w_opnd_a = '0;
        case (w_sel_a)
            OPSEL_ZERO: w_opnd_a = '0;
            OPSEL_EX:   w_opnd_a = bus.ex_fwd_data;
            OPSEL_WB:   w_opnd_a = bus.wb_data;
            OPSEL_BANK: w_opnd_a = bus.data_rs;
            default:    w_opnd_a = '0;
        endcase
    end

    always_comb begin
        w_opnd_b = '0;
        case (w_sel_b)
            OPSEL_ZERO: w_opnd_b = '0;
            OPSEL_EX:   w_opnd_b = bus.ex_fwd_data;
            OPSEL_WB:   w_opnd_b = bus.wb_data;
            OPSEL_BANK: w_opnd_b = bus.data_rt;
            default:    w_opnd_b = '0;
        endcase
    end

    // Only fields the instruction actually uses can make it illegal.
    assign w_illegal = reg_illegal(w_dec.rs)
                     | (w_dec.use_rt   & reg_illegal(w_dec.rt))
                     | (w_dec.has_dest & reg_illegal(w_dec.dest));

    // ID/EX may take a new entry when EX drains it or it holds a bubble.
    assign w_advance  = bus.out_ready | ~r_out_valid;
    assign w_in_ready = ~bus.flush & ~w_hazard & w_advance;
    assign w_accept   = bus.in_valid & w_in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid     <= 1'b0;
            r_out_pc        <= '0;
            r_out_a         <= '0;
            r_out_b         <= '0;
            r_out_imm       <= '0;
            r_out_rd        <= '0;
            r_out_opcode    <= '0;
            r_out_funct     <= '0;
            r_out_mem_read  <= 1'b0;
            r_out_mem_write <= 1'b0;
            r_out_reg_write <= 1'b0;
            r_ill_reg       <= 1'b0;
        end else begin
            r_ill_reg <= 1'b0;
            if (bus.flush) begin
                // Flush wins over stall and hazard; the entry becomes a bubble.
                r_out_valid     <= 1'b0;
                r_out_mem_read  <= 1'b0;
                r_out_mem_write <= 1'b0;
                r_out_reg_write <= 1'b0;
            end else if (w_advance) begin
                if (w_accept && !w_illegal) begin
                    r_out_valid     <= 1'b1;
                    r_out_pc        <= bus.pc;
                    r_out_a         <= w_opnd_a;
                    r_out_b         <= w_opnd_b;
                    r_out_imm       <= w_dec.imm;
                    r_out_rd        <= w_dec.has_dest ? w_dec.dest : '0;
                    r_out_opcode    <= w_dec.opcode;
                    r_out_funct     <= w_dec.funct;
                    r_out_mem_read  <= w_dec.mem_read;
                    r_out_mem_write <= w_dec.mem_write;
                    r_out_reg_write <= w_dec.has_dest && (w_dec.dest != '0);
                end else begin
                    // Hazard bubble, idle slot, or squashed illegal instruction.
                    r_out_valid     <= 1'b0;
                    r_out_mem_read  <= 1'b0;
                    r_out_mem_write <= 1'b0;
                    r_out_reg_write <= 1'b0;
                    r_ill_reg       <= w_accept & w_illegal;
                end
            end
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.ill_reg       = r_ill_reg;
    assign bus.out_valid     = r_out_valid;
    assign bus.out_pc        = r_out_pc;
    assign bus.out_a         = r_out_a;
    assign bus.out_b         = r_out_b;
    assign bus.out_imm       = r_out_imm;
    assign bus.out_rd        = r_out_rd;
    assign bus.out_opcode    = r_out_opcode;
    assign bus.out_funct     = r_out_funct;
    assign bus.out_mem_read  = r_out_mem_read;
    assign bus.out_mem_write = r_out_mem_write;
    assign bus.out_reg_write = r_out_reg_write;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage
//  Description : Self-checking bench for decode_stage: directed scenarios
//                with literal expectations followed by randomized traffic,
//                all compared every cycle against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_decode_stage;

    logic clk;
    logic rst;
    decode_stage_if bus ();

    decode_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // ---------------- model state: expected ID/EX contents ----------------
    logic        m_valid, m_mr, m_mw, m_rw, m_ill;
    logic [31:0] m_pc, m_a, m_b, m_imm;
    logic [4:0]  m_rd;
    logic [5:0]  m_opc, m_funct;

    typedef struct packed {
        logic [4:0] dest;
        logic       use_rt;
        logic       has_dest;
        logic       mr;
        logic       mw;
    } mdec_t;

    function automatic mdec_t classify(input logic [31:0] ins);
        mdec_t d;
        d = '0;
        case (ins[31:26])
            6'h00:   begin d.use_rt = 1; d.has_dest = 1; d.dest = ins[15:11]; end
            6'h23:   begin d.has_dest = 1; d.dest = ins[20:16]; d.mr = 1; end
            6'h2B:   begin d.use_rt = 1; d.mw = 1; end
            default: begin d.has_dest = 1; d.dest = ins[20:16]; end
        endcase
        return d;
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] bank);
        if (idx == 0) return 32'd0;
        if (bus.ex_fwd_en && bus.ex_fwd_rd == idx) return bus.ex_fwd_data;
        if (bus.wb_en && bus.wb_rd == idx) return bus.wb_data;
        return bank;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_valid = 0; m_mr = 0; m_mw = 0; m_rw = 0; m_ill = 0;
        m_pc = 0; m_a = 0; m_b = 0; m_imm = 0; m_rd = 0; m_opc = 0; m_funct = 0;
    endtask

    task automatic idle();
        bus.in_valid = 0; bus.instr = 0; bus.pc = 0;
        bus.data_rs = 0; bus.data_rt = 0;
        bus.ex_fwd_en = 0; bus.ex_fwd_rd = 0; bus.ex_fwd_data = 0;
        bus.wb_en = 0; bus.wb_rd = 0; bus.wb_data = 0;
        bus.flush = 0; bus.out_ready = 1;
    endtask

    // Called at a negedge with inputs applied: compares everything against
    // the model, advances one clock, and returns at the next negedge.
    task automatic cycle();
        mdec_t       d;
        logic [4:0]  rs, rt;
        logic        hz, can_move, rdy, take, bad;
        logic        n_valid, n_mr, n_mw, n_rw, n_ill;
        logic [31:0] n_pc, n_a, n_b, n_imm;
        logic [4:0]  n_rd;
        logic [5:0]  n_opc, n_funct;
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("ill_reg", 32'(bus.ill_reg), 32'(m_ill));
        chk("out_mem_read", 32'(bus.out_mem_read), 32'(m_mr));
        chk("out_mem_write", 32'(bus.out_mem_write), 32'(m_mw));
        chk("out_reg_write", 32'(bus.out_reg_write), 32'(m_rw));
        if (m_valid) begin
            chk("out_pc", bus.out_pc, m_pc);
            chk("out_a", bus.out_a, m_a);
            chk("out_b", bus.out_b, m_b);
            chk("out_imm", bus.out_imm, m_imm);
            chk("out_rd", 32'(bus.out_rd), 32'(m_rd));
            chk("out_opcode", 32'(bus.out_opcode), 32'(m_opc));
            chk("out_funct", 32'(bus.out_funct), 32'(m_funct));
        end
        rs = bus.instr[25:21];
        rt = bus.instr[20:16];
        d  = classify(bus.instr);
        chk("rs", 32'(bus.rs), 32'(rs));
        chk("rt", 32'(bus.rt), 32'(rt));
        hz = m_valid && m_mr && (m_rd != 0) && ((m_rd == rs) || (d.use_rt && m_rd == rt));
        can_move = bus.out_ready || !m_valid;
        rdy  = !bus.flush && !hz && can_move;
        take = bus.in_valid && rdy;
        bad  = (rs > 15) || (d.use_rt && rt > 15) || (d.has_dest && d.dest > 15);
        chk("in_ready", 32'(bus.in_ready), 32'(rdy));

        n_valid = m_valid; n_mr = m_mr; n_mw = m_mw; n_rw = m_rw; n_ill = 0;
        n_pc = m_pc; n_a = m_a; n_b = m_b; n_imm = m_imm; n_rd = m_rd;
        n_opc = m_opc; n_funct = m_funct;
        if (bus.flush || (can_move && !(take && !bad))) begin
            n_valid = 0; n_mr = 0; n_mw = 0; n_rw = 0;
            n_ill = !bus.flush && take && bad;
        end else if (can_move) begin
            n_valid = 1;
            n_pc    = bus.pc;
            n_a     = operand(rs, bus.data_rs);
            n_b     = operand(rt, bus.data_rt);
            n_imm   = {{16{bus.instr[15]}}, bus.instr[15:0]};
            n_rd    = d.has_dest ? d.dest : 5'd0;
            n_opc   = bus.instr[31:26];
            n_funct = bus.instr[5:0];
            n_mr    = d.mr;
            n_mw    = d.mw;
            n_rw    = d.has_dest && (d.dest != 0);
        end
        @(posedge clk);
        m_valid = n_valid; m_mr = n_mr; m_mw = n_mw; m_rw = n_rw; m_ill = n_ill;
        m_pc = n_pc; m_a = n_a; m_b = n_b; m_imm = n_imm; m_rd = n_rd;
        m_opc = n_opc; m_funct = n_funct;
        @(negedge clk);
    endtask

    function automatic logic [4:0] rand_reg();
        if ($urandom_range(0, 99) < 4) return 5'(16 + $urandom_range(0, 15));
        return 5'($urandom_range(0, 7));
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] opc;
        case ($urandom_range(0, 3))
            0:       opc = 6'h00;
            1:       opc = 6'h23;
            2:       opc = 6'h2B;
            default: opc = 6'($urandom);
        endcase
        if (opc == 6'h00)
            return {opc, rand_reg(), rand_reg(), rand_reg(), 5'($urandom), 6'($urandom)};
        return {opc, rand_reg(), rand_reg(), 16'($urandom)};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle();
        model_reset();
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk("reset_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_ill", 32'(bus.ill_reg), 32'd0);
        chk("reset_pc", bus.out_pc, 32'd0);
        rst = 0;
        cycle();

        // add r3, r1, r2 with bank r1=5, r2=7
        bus.in_valid = 1; bus.instr = 32'h00221820; bus.pc = 32'h100;
        bus.data_rs = 5; bus.data_rt = 7;
        cycle();
        chk("add_a", bus.out_a, 32'd5);
        chk("add_b", bus.out_b, 32'd7);
        chk("add_rd", 32'(bus.out_rd), 32'd3);
        chk("add_rw", 32'(bus.out_reg_write), 32'd1);

        // lw r4, 0(r1) then add r5, r4, r4
        bus.instr = 32'h8C240000; bus.pc = 32'h104; bus.data_rs = 32'h200;
        cycle();
        chk("lw_mr", 32'(bus.out_mem_read), 32'd1);
        bus.instr = 32'h00842820; bus.pc = 32'h108;
        #1;
        chk("lu_in_ready_low", 32'(bus.in_ready), 32'd0);
        cycle();
        chk("lu_bubble", 32'(bus.out_valid), 32'd0);
        bus.ex_fwd_en = 1; bus.ex_fwd_rd = 4; bus.ex_fwd_data = 32'hDEADBEEF;
        #1;
        chk("lu_in_ready_high", 32'(bus.in_ready), 32'd1);
        cycle();
        chk("lu_a", bus.out_a, 32'hDEADBEEF);
        chk("lu_b", bus.out_b, 32'hDEADBEEF);

        // EX beats WB; register 0 reads as 0 even when a bypass names it
        idle();
        bus.in_valid = 1; bus.instr = 32'h00E03020; bus.data_rs = 32'h99; bus.data_rt = 32'h98;
        bus.ex_fwd_en = 1; bus.ex_fwd_rd = 7; bus.ex_fwd_data = 32'h11;
        bus.wb_en = 1; bus.wb_rd = 7; bus.wb_data = 32'h22;
        cycle();
        chk("byp_ex_wins", bus.out_a, 32'h11);
        bus.instr = 32'h00073020; bus.ex_fwd_rd = 0; bus.ex_fwd_data = 32'h33;
        cycle();
        chk("byp_r0", bus.out_a, 32'h0);
        chk("byp_wb", bus.out_b, 32'h22);

        // stall three cycles, then flush during the stall
        idle();
        bus.in_valid = 1; bus.instr = 32'h00221820; bus.data_rs = 5; bus.data_rt = 7;
        cycle();
        bus.out_ready = 0; bus.instr = 32'h00431020;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            cycle();
            chk("stall_a", bus.out_a, 32'd5);
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.flush = 1;
        cycle();
        chk("stall_flush", 32'(bus.out_valid), 32'd0);

        // rs = 17 is illegal
        idle();
        bus.in_valid = 1; bus.instr = 32'h02221820;
        cycle();
        chk("ill_pulse", 32'(bus.ill_reg), 32'd1);
        chk("ill_valid", 32'(bus.out_valid), 32'd0);
        idle();
        cycle();
        chk("ill_clear", 32'(bus.ill_reg), 32'd0);

        // reset mid-stall
        bus.in_valid = 1; bus.instr = 32'h00221820; bus.data_rs = 5; bus.data_rt = 7;
        cycle();
        bus.out_ready = 0;
        cycle();
        rst = 1;
        #1;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_a", bus.out_a, 32'd0);
        chk("rst_rw", 32'(bus.out_reg_write), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        bus.out_ready = 1;
        cycle();
        chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
        chk("post_rst_b", bus.out_b, 32'd7);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid    = ($urandom_range(0, 3) != 0);
            bus.instr       = rand_instr();
            bus.pc          = $urandom;
            bus.data_rs     = $urandom;
            bus.data_rt     = $urandom;
            bus.ex_fwd_en   = 1'($urandom);
            bus.ex_fwd_rd   = rand_reg();
            bus.ex_fwd_data = $urandom;
            bus.wb_en       = 1'($urandom);
            bus.wb_rd       = rand_reg();
            bus.wb_data     = $urandom;
            bus.flush       = ($urandom_range(0, 15) == 0);
            bus.out_ready   = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have one clock and asynchronous active-high reset: clk input 1 (rising-edge clock); rst input 1 (asynchronous, active-high reset).
REQ-002 The block SHALL provide these fetch-side ports: in_valid input 1 (instruction present); in_ready output 1 (decode accepts); instr input 32; pc input 32.
REQ-003 The block SHALL provide these register-bank ports: rs output 5 (instr[25:21]); rt output 5 (instr[20:16]); data_rs input 32; data_rt input 32 (combinational read data for rs/rt).
REQ-004 The block SHALL provide these bypass ports: ex_fwd_en input 1; ex_fwd_rd input 5; ex_fwd_data input 32 (result leaving EX); wb_en input 1; wb_rd input 5; wb_data input 32 (the same write presented to the bank en/rd/data).
REQ-005 The block SHALL provide these control ports: flush input 1 (branch redirect); out_ready input 1 (EX can accept); ill_reg output 1 (one-cycle pulse).
REQ-006 The block SHALL provide these ID/EX outputs, all registered: out_valid 1; out_pc 32; out_a 32; out_b 32; out_imm 32; out_rd 5; out_opcode 6; out_funct 6; out_mem_read 1; out_mem_write 1; out_reg_write 1.

Function
REQ-007 Decode SHALL use opcode = instr[31:26], rd = instr[15:11], funct = instr[5:0], and imm = sign-extended instr[15:0].
REQ-008 Opcode classes SHALL be: 0x00 = R-type (dest rd, uses rs and rt); 0x23 = load (dest rt, mem_read, uses rs); 0x2B = store (no dest, mem_write, uses rs and rt); any other opcode = I-type ALU (dest rt, uses rs).
REQ-009 A destination of register 0 SHALL force out_reg_write to 0.
REQ-010 Operand select SHALL apply, per source, in priority order: index 0 gives 0; a match on ex_fwd_en && ex_fwd_rd gives ex_fwd_data; a match on wb_en && wb_rd gives wb_data; otherwise data_rs or data_rt.
REQ-011 Load-use hazard SHALL be raised when out_valid && out_mem_read && out_rd != 0 and out_rd equals a used source field.
REQ-012 in_ready SHALL equal !hazard && (out_ready || !out_valid).
REQ-013 The ID/EX register SHALL advance on each clk edge when out_ready || !out_valid, with priority as follows:
  - flush: out_valid <= 0.
  - hazard: bubble; out_valid <= 0 and the instruction is held (not accepted).
  - in_valid && in_ready: load the decoded instruction, out_valid <= 1.
  - otherwise: out_valid <= 0.
REQ-014 When neither out_ready nor !out_valid holds, all ID/EX outputs SHALL hold their values (stall), except that flush SHALL still clear out_valid.
REQ-015 Any used register field, or the destination, with bit 4 set (index > 15) SHALL convert the accepted instruction into a bubble (out_valid <= 0) and pulse ill_reg for one cycle.
REQ-016 Latency SHALL be exactly one cycle from acceptance to out_valid.
REQ-017 Bubbles SHALL have out_reg_write = 0, out_mem_read = 0 and out_mem_write = 0.
REQ-018 Simultaneous flush and hazard SHALL resolve to flush, and in_ready SHALL be 0 during flush.

Reset
REQ-019 While rst = 1, all registered outputs SHALL be 0 (including out_valid and ill_reg), independent of clk.
REQ-020 Release of rst SHALL make the block accept on the first subsequent clk edge where in_valid = 1.
REQ-021 A reset asserted mid-stall SHALL discard the held instruction.

Structure
REQ-022 The opcode constants (R-type 0x00, LW 0x23, SW 0x2B), field bit positions and the register count (16) SHALL live in a shared package.
REQ-023 Hazard and forwarding comparison SHALL be a single sub-module, hazard_unit, that outputs hazard and the two operand-select codes.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
  - R-type add r3, r1, r2, bank r1 = 5, r2 = 7, no bypass -> next cycle out_a = 5, out_b = 7, out_rd = 3, out_reg_write = 1.
  - lw r4, 0(r1) followed by add r5, r4, r4 -> in_ready = 0 for one cycle, one bubble, then the add issues with out_a = out_b = ex_fwd_data.
  - Same source on EX and WB bypass, ex_fwd_data = 0x11, wb_data = 0x22 -> operand = 0x11; a rd = 0 match -> operand = 0.
  - out_ready = 0 for 3 cycles with a valid instruction held -> outputs stable, in_ready = 0; flush during the stall -> out_valid = 0 next edge.
  - Instruction with rs = 17 -> ill_reg pulses one cycle, out_valid = 0.
  - rst asserted mid-stall -> all outputs 0 immediately; after release, the first instruction appears one cycle after acceptance.
